mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Clocked, parametrised load/store unit for the RV32I MEM stage; successor to the combinational byte-port load path.
- Splits LB/LH/LW/LBU/LHU and SB/SH/SW into beats over NPORTS byte-wide synchronous memory ports.
- Assembles and extends load data, and holds the pipeline via `stall` until a registered response is returned.
- Adds stores, a valid/ready handshake, a misalignment/illegal-funct3 fault, and reset-safe abort.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- NPORTS, 2, number of byte ports; legal values are 1, 2, 4.
- ALLOW_MISALIGNED, 1, 1 = misaligned accesses are split byte-wise; 0 = misaligned accesses fault.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM-stage request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (low bytes used)
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults
- resp_fault  out  1  misaligned (when ALLOW_MISALIGNED=0) or illegal funct3
- stall  out  1  pipeline hold
- mem_en  out  NPORTS  per-port enable
- mem_we  out  NPORTS  per-port write enable
- mem_addr  out  NPORTS*XLEN  per-port byte address; port p occupies bits [p*XLEN +: XLEN]
- mem_wdata  out  NPORTS*8  per-port write byte
- mem_rdata  in  NPORTS*8  per-port read byte; valid the cycle after its address is driven

Behaviour:
- Reset: all outputs 0 and state = IDLE. Reset mid-operation aborts the access: no `resp_valid`, no further memory enables.
- Accept: request accepted on a rising edge with `req_valid && req_ready`; inputs are latched at that edge.
- Access size S: 1 for funct3 000/100; 2 for 001/101; 4 for 010.
- Legal funct3: loads accept 000, 001, 010, 100, 101; stores accept 000, 001, 010. Anything else is illegal.
- Beat count: B = ceil(S/NPORTS).
- Byte mapping: byte i of the access goes to port (i mod NPORTS) in beat (i / NPORTS), address req_addr+i. Ports without a byte in a beat have `mem_en=0`.
- Store data: byte i = req_wdata[8i+7:8i], little-endian.
- Address wrap: addr+i wraps modulo 2^32 (e.g. 0xFFFFFFFF+1 = 0x00000000).
- FSM states: IDLE, ISSUE, DRAIN, RESP, FAULT. Cycle k means the k-th cycle after the accept edge.
  - IDLE: on accept, go to FAULT if the request is illegal, or misaligned with ALLOW_MISALIGNED=0; otherwise go to ISSUE with beat counter 0.
  - ISSUE: drive beat b in cycle 1+b. For loads, `mem_en` is set; for stores, `mem_en` and `mem_we` are set. After beat B-1: stores go to RESP, loads go to DRAIN.
  - Load capture: data for beat b is captured at the end of cycle 2+b. Capture is pipelined alongside the next beat's issue.
  - DRAIN: captures the last beat, then goes to RESP.
  - RESP: `resp_valid=1` for one cycle, then IDLE. Loads respond in cycle B+2; stores respond in cycle B+1.
  - FAULT: no memory activity; `resp_valid=1` and `resp_fault=1` in cycle 1, then IDLE.
- Misalignment: S=2 with addr[0]≠0, or S=4 with addr[1:0]≠0.
- Extension: 000 sign-extends from bit 7; 001 sign-extends from bit 15; 100/101 zero-extend; 010 passes through.
- `resp_rdata` holds its value only during `resp_valid` and is 0 otherwise.
- stall = (state≠IDLE && state≠RESP) || (state==IDLE && req_valid).
  - It drops in the RESP cycle so the pipeline advances with the data.
- `req_valid` deasserted while busy is ignored; the latched request completes.

Decomposition:
- Shared package mem_access_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding.
  - size-decode function.
- Sub-module load_extend: combinational funct3 + raw 32-bit assembled data -> extended result, shared with future cache path.

Test Plan:
- Memory 0x100..0x103 = 80,7F,01,FF, NPORTS=2:
  - LB 0x100 -> 0xFFFFFF80.
  - LBU 0x100 -> 0x00000080.
  - LH 0x102 -> 0xFFFFFF01.
  - LHU 0x102 -> 0x0000FF01.
  - resp_valid in cycle 3 for all four.
- LW 0x100: NPORTS=1 -> resp cycle 6; NPORTS=2 -> cycle 4; NPORTS=4 -> cycle 3. All return 0xFF017F80; stall is high in cycles 0..resp-1.
- SW 0x200 wdata 0xDEADBEEF, NPORTS=4:
  - cycle 1: mem_en=mem_we=1111, bytes EF,BE,AD,DE at 0x200..0x203.
  - resp cycle 2; readback LW = 0xDEADBEEF.
- LW 0x101:
  - ALLOW_MISALIGNED=0 -> no mem_en; resp cycle 1, fault=1, rdata=0.
  - ALLOW_MISALIGNED=1 -> bytes 0x101..0x104 returned; fault=0.
- funct3=011 load, and store with funct3=100 -> fault=1, no memory access.
- Assert rst in cycle 2 of an NPORTS=1 LW:
  - outputs 0 immediately; no resp_valid.
  - next request after reset completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store path: funct3 codes, FSM states, access decode.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP,
        ST_FAULT
    } state_t;

    // Access size in bytes; 0 marks a funct3 with no load/store meaning.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd0;
        endcase
        return size;
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we)
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            ok = (access_size(funct3) != 3'd0);
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        return ((size == 3'd2) && addr_lo[0]) || ((size == 3'd4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// MEM-stage request/response handshake plus the byte-wide memory port bundle.
interface mem_access_if #(
    parameter int XLEN   = 32,
    parameter int NPORTS = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [2:0]             req_funct3;
    logic [XLEN-1:0]        req_addr;
    logic [XLEN-1:0]        req_wdata;
    logic                   resp_valid;
    logic [XLEN-1:0]        resp_rdata;
    logic                   resp_fault;
    logic                   stall;
    logic [NPORTS-1:0]      mem_en;
    logic [NPORTS-1:0]      mem_we;
    logic [NPORTS*XLEN-1:0] mem_addr;
    logic [NPORTS*8-1:0]    mem_wdata;
    logic [NPORTS*8-1:0]    mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data by funct3.
// Purely combinational, no backpressure.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] result
);
    always_comb begin
        case (funct3)
            F3_B:    result = {{24{raw[7]}}, raw[7:0]};
            F3_H:    result = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   result = {24'h000000, raw[7:0]};
            F3_HU:   result = {16'h0000, raw[15:0]};
            default: result = raw;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store unit splitting accesses into beats over NPORTS byte-wide sync memory ports.
// Latency: loads B+2, stores B+1, faults 1 cycle after accept; one request in flight, stall holds the pipe.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int NPORTS           = 2,
    parameter int ALLOW_MISALIGNED = 1
)(
    input  logic       clk,
    input  logic       rst,
    mem_access_if.slave bus
);
    state_t              state_q, state_d;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [2:0]          size_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [1:0]          beat_q;
    logic [1:0]          last_beat;
    logic [31:0]         data_q, data_d;
    logic [31:0]         ext_data;
    logic [2:0]          req_size;
    logic                req_bad;
    logic [1:0]          cap_beat;
    logic                cap_en;
    logic [3:0]          lane_idx;
    logic [3:0]          cap_idx;
    logic [NPORTS-1:0]   mem_en_c, mem_we_c;
    logic [NPORTS*XLEN-1:0] mem_addr_c;
    logic [NPORTS*8-1:0] mem_wdata_c;

    assign req_size  = access_size(bus.req_funct3);
    assign req_bad   = !funct3_legal(bus.req_we, bus.req_funct3) ||
                       ((ALLOW_MISALIGNED == 0) && misaligned(req_size, bus.req_addr[1:0]));
    assign last_beat = 2'((int'(size_q) + NPORTS - 1) / NPORTS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_fault  = 1'b0;
        bus.stall       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = !rst;
                bus.stall     = !rst && bus.req_valid;
                if (bus.req_valid)
                    state_d = req_bad ? ST_FAULT : ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.stall = 1'b1;
                if (beat_q == last_beat)
                    state_d = we_q ? ST_RESP : ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.stall = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_FAULT: begin
                bus.stall      = 1'b1;
                bus.resp_valid = 1'b1;
                bus.resp_fault = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data for a beat arrives one cycle after issue, so capture trails issue by one beat.
    assign cap_beat = (state_q == ST_DRAIN) ? beat_q : beat_q - 2'd1;
    assign cap_en   = !we_q && ((state_q == ST_DRAIN) || ((state_q == ST_ISSUE) && (beat_q != 2'd0)));

    always_comb begin
        mem_en_c    = '0;
        mem_we_c    = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        data_d      = data_q;
        lane_idx    = '0;
        cap_idx     = '0;
        for (int p = 0; p < NPORTS; p++) begin
            lane_idx = 4'(int'(beat_q) * NPORTS + p);
            if ((state_q == ST_ISSUE) && (lane_idx < 4'(size_q))) begin
                mem_en_c[p]                 = 1'b1;
                mem_we_c[p]                 = we_q;
                mem_addr_c[p*XLEN +: XLEN]  = addr_q + XLEN'(lane_idx);
                mem_wdata_c[p*8 +: 8]       = 8'(wdata_q >> {lane_idx[1:0], 3'b000});
            end
            cap_idx = 4'(int'(cap_beat) * NPORTS + p);
            if (cap_en && (cap_idx < 4'(size_q)))
                data_d[{cap_idx[1:0], 3'b000} +: 8] = bus.mem_rdata[p*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            size_q   <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            beat_q   <= 2'd0;
            data_q   <= 32'h0;
        end else begin
            data_q <= data_d;
            if ((state_q == ST_IDLE) && bus.req_valid) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                size_q   <= req_size;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                beat_q   <= 2'd0;
            end else if ((state_q == ST_ISSUE) && (beat_q != last_beat)) begin
                beat_q <= beat_q + 2'd1;
            end
        end
    end

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (data_q),
        .result (ext_data)
    );

    assign bus.resp_rdata = ((state_q == ST_RESP) && !we_q) ? XLEN'(ext_data) : '0;
    assign bus.mem_en     = mem_en_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;

endmodule
